// File: rtl/data_mem_responder.sv
// Data-memory responder for the RISC_TOY core: single-port word SRAM behind a
// one-entry posted-write buffer, with out-of-range flag and saturating access counters.
module data_mem_responder #(
  parameter int unsigned AW = 10,
  parameter int unsigned CW = 16
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          DREQ,
  input  logic          DRW,
  input  logic [29:0]   DADDR,
  input  logic [31:0]   DWDATA,
  output logic [31:0]   DRDATA,
  output logic          DERR,
  output logic [CW-1:0] RD_CNT,
  output logic [CW-1:0] WR_CNT
);

  typedef enum logic {
    EMPTY,
    FULL
  } buf_state_e;

  buf_state_e      state;
  logic [AW-1:0]   baddr;
  logic [31:0]     bdata;
  logic [31:0]     mem [2**AW];

  logic [AW-1:0]   idx;
  logic            in_range;
  logic            rd_ok;
  logic            wr_ok;
  logic            oor;
  logic            hit;
  logic            commit;

  always_comb begin
    idx      = DADDR[AW-1:0];
    in_range = (DADDR >> AW) == '0;
    rd_ok    = DREQ & ~DRW & in_range;
    wr_ok    = DREQ & DRW & in_range;
    oor      = DREQ & ~in_range;
    hit      = (state == FULL) && (idx == baddr);
    // The single array port drains the buffer whenever no in-range read needs it
    // and the buffered word is not simply being overwritten in place.
    commit   = (state == FULL) && (!(rd_ok || wr_ok) || (wr_ok && !hit));
  end

  always_ff @(posedge CLK) begin
    if (commit) begin
      mem[baddr] <= bdata;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state  <= EMPTY;
      baddr  <= '0;
      bdata  <= '0;
      DRDATA <= '0;
      DERR   <= 1'b0;
      RD_CNT <= '0;
      WR_CNT <= '0;
    end else begin
      DERR <= oor;

      if (rd_ok) begin
        DRDATA <= hit ? bdata : mem[idx];
      end else if (oor && !DRW) begin
        DRDATA <= '0;
      end

      if (rd_ok && (RD_CNT != '1)) begin
        RD_CNT <= RD_CNT + 1'b1;
      end
      if (wr_ok && (WR_CNT != '1)) begin
        WR_CNT <= WR_CNT + 1'b1;
      end

      unique case (state)
        EMPTY: begin
          if (wr_ok) begin
            baddr <= idx;
            bdata <= DWDATA;
            state <= FULL;
          end
        end
        FULL: begin
          if (wr_ok) begin
            baddr <= idx;
            bdata <= DWDATA;
          end else if (!rd_ok) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a flat-memory
// reference model in which every write is visible to all later reads.
module tb_data_mem_responder;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        DREQ = 1'b0;
  logic        DRW = 1'b0;
  logic [29:0] DADDR = '0;
  logic [31:0] DWDATA = '0;
  logic [31:0] DRDATA, DRDATA4;
  logic        DERR, DERR4;
  logic [15:0] RD_CNT, WR_CNT;
  logic [3:0]  RD_CNT4, WR_CNT4;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: logical memory contents and expected outputs.
  logic [31:0] model [1024];
  bit          known [1024];
  logic [31:0] exp_rd;
  bit          rd_known;
  int unsigned exp_rd_cnt, exp_wr_cnt, exp_rd4, exp_wr4;

  data_mem_responder #(.AW(10), .CW(16)) dut (
    .CLK(CLK), .RSTN(RSTN), .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR),
    .DWDATA(DWDATA), .DRDATA(DRDATA), .DERR(DERR), .RD_CNT(RD_CNT), .WR_CNT(WR_CNT)
  );

  data_mem_responder #(.AW(10), .CW(4)) dut4 (
    .CLK(CLK), .RSTN(RSTN), .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR),
    .DWDATA(DWDATA), .DRDATA(DRDATA4), .DERR(DERR4), .RD_CNT(RD_CNT4), .WR_CNT(WR_CNT4)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("derr", 32'(DERR), exp_rd_cnt == exp_rd_cnt ? 32'(0) : 32'(0));
  endtask

  // One bus cycle: drive on the falling edge, check registered outputs after the rising edge.
  task automatic cyc(input bit req, input bit rw, input logic [29:0] addr, input logic [31:0] wd);
    bit           inr;
    logic [9:0]   ix;
    bit           exp_err;
    @(negedge CLK);
    DREQ = req; DRW = rw; DADDR = addr; DWDATA = wd;
    @(posedge CLK);
    #1;
    inr = (addr >> 10) == 0;
    ix  = addr[9:0];
    exp_err = req && !inr;
    if (req && !rw) begin
      if (inr) begin
        exp_rd   = model[ix];
        rd_known = known[ix];
        if (exp_rd_cnt != 32'hFFFF) exp_rd_cnt++;
        if (exp_rd4 != 15) exp_rd4++;
      end else begin
        exp_rd   = '0;
        rd_known = 1'b1;
      end
    end
    if (req && rw && inr) begin
      model[ix] = wd;
      known[ix] = 1'b1;
      if (exp_wr_cnt != 32'hFFFF) exp_wr_cnt++;
      if (exp_wr4 != 15) exp_wr4++;
    end
    check("derr", 32'(DERR), 32'(exp_err));
    check("derr4", 32'(DERR4), 32'(exp_err));
    check("rd_cnt", 32'(RD_CNT), exp_rd_cnt);
    check("wr_cnt", 32'(WR_CNT), exp_wr_cnt);
    check("rd_cnt4", 32'(RD_CNT4), exp_rd4);
    check("wr_cnt4", 32'(WR_CNT4), exp_wr4);
    if (rd_known) begin
      check("drdata", DRDATA, exp_rd);
      check("drdata4", DRDATA4, exp_rd);
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge CLK);
    DREQ = 1'b0;
    #2;
    RSTN = 1'b0;
    #1;
    check("rst_drdata", DRDATA, 32'h0);
    check("rst_derr", 32'(DERR), 32'h0);
    check("rst_rd_cnt", 32'(RD_CNT), 32'h0);
    check("rst_wr_cnt", 32'(WR_CNT), 32'h0);
    check("rst_rd_cnt4", 32'(RD_CNT4), 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
    exp_rd = '0; rd_known = 1'b1;
    exp_rd_cnt = 0; exp_wr_cnt = 0; exp_rd4 = 0; exp_wr4 = 0;
  endtask

  initial begin
    logic [31:0] prior;
    for (int i = 0; i < 1024; i++) begin
      known[i] = 1'b0;
      model[i] = '0;
    end
    exp_rd = '0; rd_known = 1'b1;
    exp_rd_cnt = 0; exp_wr_cnt = 0; exp_rd4 = 0; exp_wr4 = 0;
    do_reset();

    // Write, idle, read.
    cyc(1, 1, 30'h004, 32'hDEADBEEF);
    cyc(0, 0, 30'h0, 32'h0);
    cyc(1, 0, 30'h004, 32'h0);
    check("t1_data", DRDATA, 32'hDEADBEEF);

    // Back-to-back write then read of the same address.
    cyc(1, 1, 30'h010, 32'h11);
    cyc(1, 0, 30'h010, 32'h0);
    check("t2_bypass", DRDATA, 32'h11);
    cyc(0, 0, 30'h0, 32'h0);

    // Buffer overwrite/evict sequence.
    cyc(1, 1, 30'h001, 32'hA);
    cyc(1, 1, 30'h002, 32'hB);
    cyc(1, 1, 30'h001, 32'hC);
    cyc(1, 0, 30'h001, 32'h0);
    check("t3_rd1", DRDATA, 32'hC);
    cyc(1, 0, 30'h002, 32'h0);
    check("t3_rd2", DRDATA, 32'hB);
    check("t3_arr_old", dut.mem[1], 32'hA);
    cyc(0, 0, 30'h0, 32'h0);
    check("t3_arr_new", dut.mem[1], 32'hC);

    // Out-of-range accesses alias index 0 but must not touch it.
    cyc(1, 1, 30'h000, 32'h12345678);
    cyc(0, 0, 30'h0, 32'h0);
    cyc(1, 0, 30'h400, 32'h0);
    check("t4_oor_rd", DRDATA, 32'h0);
    cyc(1, 1, 30'h400, 32'hFFFFFFFF);
    cyc(0, 0, 30'h0, 32'h0);
    cyc(1, 0, 30'h000, 32'h0);
    check("t4_idx0", DRDATA, 32'h12345678);

    // Reset while a write is still buffered loses that write.
    cyc(1, 1, 30'h008, 32'h77);
    cyc(0, 0, 30'h0, 32'h0);
    prior = model[8];
    cyc(1, 1, 30'h008, 32'h55);
    do_reset();
    model[8] = prior;
    cyc(1, 0, 30'h008, 32'h0);
    check("t5_lost_wr", DRDATA, 32'h77);

    // Counter saturation on the narrow-counter instance.
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1, 0, 30'h004, 32'h0);
    check("t6_sat", 32'(RD_CNT4), 32'hF);
    check("t6_wide", 32'(RD_CNT), 32'd20);

    // Randomized traffic over a small address window plus out-of-range hits.
    for (int i = 0; i < 600; i++) begin
      logic [29:0] a;
      bit r, w;
      r = $urandom_range(0, 3) != 0;
      w = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) == 0) a = 30'($urandom) | 30'h400;
      else a = 30'($urandom_range(0, 7));
      cyc(r, w, a, $urandom);
    end
    cyc(0, 0, 30'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
